// File: rtl/run_sequencer.sv
// run_sequencer: holds the core in reset while a host streams a data-memory
// image, then launches the core, times its run and reports completion.
// Ports: clk, reset (async, active-low); host side start/ld_valid/ld_last/
// ld_addr/ld_data/ld_ready; core side core_rst/core_req/core_done;
// memory side dm_wr_en/dm_addr/dm_dat; status busy/finished/timeout/
// cycle_count. Optional watchdog: define RUN_SEQ_WATCHDOG_EN.
module run_sequencer #(
  parameter int              AW         = 8,
  parameter int              CW         = 16,
  parameter logic [CW-1:0]   MAX_CYCLES = 16'd4000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          ld_valid,
  input  logic          ld_last,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_data,
  output logic          ld_ready,
  output logic          core_rst,
  output logic          core_req,
  input  logic          core_done,
  output logic          dm_wr_en,
  output logic [AW-1:0] dm_addr,
  output logic [7:0]    dm_dat,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    LAUNCH,
    RUN,
    DONE
  } state_t;

  state_t state;

`ifdef RUN_SEQ_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  // With the watchdog compiled out this is constant 0, so timeout
  // never sets and RUN waits for core_done indefinitely.
  logic wd_hit;
  assign wd_hit = WD_EN && (cycle_count >= MAX_CYCLES);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      ld_ready    <= 1'b0;
      core_rst    <= 1'b1;
      core_req    <= 1'b0;
      dm_wr_en    <= 1'b0;
      dm_addr     <= '0;
      dm_dat      <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      dm_wr_en <= 1'b0;
      core_req <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            ld_ready    <= 1'b1;
            busy        <= 1'b1;
            core_rst    <= 1'b1;
            finished    <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        LOAD: begin
          if (ld_valid) begin
            dm_wr_en <= 1'b1;
            dm_addr  <= ld_addr;
            dm_dat   <= ld_data;
            // Final write lands in LAUNCH, before the first fetch.
            if (ld_last) begin
              state    <= LAUNCH;
              ld_ready <= 1'b0;
              core_rst <= 1'b0;
              core_req <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          state <= RUN;
        end
        RUN: begin
          if (core_done) begin
            state    <= DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
          end else if (wd_hit) begin
            state    <= DONE;
            busy     <= 1'b0;
            finished <= 1'b1;
            timeout  <= 1'b1;
          end else if (cycle_count != {CW{1'b1}}) begin
            cycle_count <= cycle_count + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: table-driven and randomized self-checking bench
// for run_sequencer, with a behavioural model of load/run timing.
module tb_run_sequencer;

  localparam int AW   = 8;
  localparam int CW   = 16;
  localparam int MAXC = 20;
`ifdef RUN_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          ld_valid;
  logic          ld_last;
  logic [AW-1:0] ld_addr;
  logic [7:0]    ld_data;
  logic          ld_ready;
  logic          core_rst;
  logic          core_req;
  logic          core_done;
  logic          dm_wr_en;
  logic [AW-1:0] dm_addr;
  logic [7:0]    dm_dat;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [CW-1:0] cycle_count;

  run_sequencer #(
    .AW(AW),
    .CW(CW),
    .MAX_CYCLES(16'(MAXC))
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .start(start),
    .ld_valid(ld_valid),
    .ld_last(ld_last),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .ld_ready(ld_ready),
    .core_rst(core_rst),
    .core_req(core_req),
    .core_done(core_done),
    .dm_wr_en(dm_wr_en),
    .dm_addr(dm_addr),
    .dm_dat(dm_dat),
    .busy(busy),
    .finished(finished),
    .timeout(timeout),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst"}, core_rst, 1);
    chk({tag, "_ld_ready"}, ld_ready, 0);
    chk({tag, "_core_req"}, core_req, 0);
    chk({tag, "_dm_wr_en"}, dm_wr_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_finished"}, finished, 0);
    chk({tag, "_timeout"}, timeout, 0);
    chk({tag, "_count"}, cycle_count, 0);
  endtask

  // Starts a job from IDLE/DONE and streams words {addr,data}.
  // Noisy mode adds idle gaps with stray ld_last, and toggles
  // start/core_done, all of which must be ignored while loading.
  task automatic load_words(input logic [15:0] w[$], input bit noisy);
    int        i;
    bit        acc;
    logic [7:0] ea;
    logic [7:0] ed;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("load_ready", ld_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_core_rst", core_rst, 1);
    chk("load_count_clr", cycle_count, 0);
    chk("load_timeout_clr", timeout, 0);
    chk("load_finished_clr", finished, 0);
    i = 0;
    while (i < w.size()) begin
      if (noisy && $urandom_range(0, 2) == 0) begin
        ld_valid = 1'b0;
        ld_last  = 1'($urandom_range(0, 1));
        ld_addr  = 8'($urandom);
        ld_data  = 8'($urandom);
        acc      = 1'b0;
      end else begin
        {ea, ed} = w[i];
        ld_valid = 1'b1;
        ld_last  = (i == w.size() - 1);
        ld_addr  = ea;
        ld_data  = ed;
        acc      = 1'b1;
        i++;
      end
      start     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      core_done = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      chk("wr_en", dm_wr_en, 32'(acc));
      if (acc) begin
        chk("wr_addr", dm_addr, ea);
        chk("wr_data", dm_dat, ed);
      end
      if (i < w.size()) begin
        chk("load_ready_hold", ld_ready, 1);
        chk("load_no_req", core_req, 0);
      end
    end
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    start     = 1'b0;
    core_done = 1'b0;
    chk("launch_req", core_req, 1);
    chk("launch_core_rst", core_rst, 0);
    chk("launch_ready", ld_ready, 0);
    chk("launch_busy", busy, 1);
  endtask

  // Model: the Nth RUN cycle ending with core_done leaves count N-1;
  // with the watchdog, a RUN cycle entered with count >= limit ends
  // the run with timeout instead (core_done in that cycle wins).
  task automatic run_phase(input int done_at, input int budget,
                           output bit fin, output int cnt);
    bit hd;
    bit hw;
    bit to;
    fin = 1'b0;
    to  = 1'b0;
    cnt = budget;
    core_done = 1'($urandom_range(0, 1));
    start     = 1'($urandom_range(0, 1));
    tick();
    chk("run_req_drop", core_req, 0);
    chk("run_core_rst", core_rst, 0);
    chk("run_wr_idle", dm_wr_en, 0);
    for (int k = 1; k <= budget; k++) begin
      hd = (k == done_at);
      hw = WD && !hd && (k - 1 >= MAXC);
      core_done = hd;
      start     = 1'($urandom_range(0, 1));
      tick();
      if (hd || hw) begin
        fin = 1'b1;
        cnt = k - 1;
        to  = hw;
        break;
      end
      chk("run_count", cycle_count, k);
      chk("run_busy", busy, 1);
      chk("run_req_low", core_req, 0);
    end
    core_done = 1'b0;
    start     = 1'b0;
    chk("end_finished", finished, 32'(fin));
    chk("end_busy", busy, 32'(!fin));
    chk("end_count", cycle_count, cnt);
    chk("end_timeout", timeout, 32'(to));
    chk("end_core_rst", core_rst, 0);
  endtask

  task automatic done_hold(input int exp_cnt);
    for (int k = 0; k < 3; k++) begin
      core_done = 1'($urandom_range(0, 1));
      tick();
      chk("done_hold_cnt", cycle_count, exp_cnt);
      chk("done_hold_fin", finished, 1);
    end
    core_done = 1'b0;
  endtask

  task automatic reset_pulse();
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk_reset_vals("post_rst");
  endtask

  typedef struct {
    int nwords;
    int done_at;
    int budget;
    bit fin;
    int cnt;
    bit to;
  } vec_t;

  vec_t        tbl[5];
  logic [15:0] wq[$];
  bit          mfin;
  int          mcnt;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    core_done = 1'b0;

    tbl[0] = '{4, 10, 40, 1'b1, 9, 1'b0};
    tbl[1] = '{1, 1, 40, 1'b1, 0, 1'b0};
    tbl[2] = '{3, 21, 40, 1'b1, 20, 1'b0};
    tbl[3] = '{5, 2, 40, 1'b1, 1, 1'b0};
    tbl[4] = '{2, 0, 100, WD, WD ? 20 : 100, WD};

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_addr", dm_addr, 0);
    chk("reset_data", dm_dat, 0);
    rst_n = 1'b1;
    tick();
    chk_reset_vals("idle");

    // Fixed image from the bring-up flow.
    wq = {};
    wq.push_back(16'h00A5);
    wq.push_back(16'h015A);
    wq.push_back(16'h02FF);
    wq.push_back(16'h0300);
    load_words(wq, 1'b0);
    run_phase(10, 40, mfin, mcnt);
    chk("fixed_count", cycle_count, 9);
    chk("fixed_fin", finished, 1);
    chk("fixed_to", timeout, 0);
    done_hold(9);

    // Restart from DONE with a single word.
    wq = {};
    wq.push_back(16'h1234);
    load_words(wq, 1'b0);
    run_phase(3, 40, mfin, mcnt);
    chk("restart_count", cycle_count, 2);

    for (int t = 0; t < 5; t++) begin
      wq = {};
      for (int i = 0; i < tbl[t].nwords; i++)
        wq.push_back({8'(i), 8'($urandom)});
      load_words(wq, 1'b1);
      run_phase(tbl[t].done_at, tbl[t].budget, mfin, mcnt);
      chk("tbl_fin", finished, 32'(tbl[t].fin));
      chk("tbl_count", cycle_count, tbl[t].cnt);
      chk("tbl_timeout", timeout, 32'(tbl[t].to));
      chk("tbl_busy", busy, 32'(!tbl[t].fin));
      if (!mfin) reset_pulse();
    end

    // Async reset mid-RUN at count 5.
    wq = {};
    wq.push_back(16'h0742);
    load_words(wq, 1'b0);
    run_phase(0, 5, mfin, mcnt);
    chk("midrun_count", cycle_count, 5);
    reset_pulse();

    // Async reset with a write pending mid-LOAD.
    start = 1'b1;
    tick();
    start    = 1'b0;
    ld_valid = 1'b1;
    ld_last  = 1'b0;
    ld_addr  = 8'h10;
    ld_data  = 8'h77;
    tick();
    ld_valid = 1'b0;
    chk("midload_wr", dm_wr_en, 1);
    reset_pulse();

    for (int r = 0; r < 25; r++) begin
      int n;
      int d;
      n = $urandom_range(1, 6);
      d = $urandom_range(1, 30);
      wq = {};
      for (int i = 0; i < n; i++)
        wq.push_back(16'($urandom));
      load_words(wq, 1'b1);
      run_phase(d, 40, mfin, mcnt);
      if (!mfin) reset_pulse();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Host-side launch controller sitting directly upstream of the processor top level. It holds the core in reset while a host streams an initial data-memory image through it, then releases the core and issues the one-cycle `req` pulse. It waits for the core's `done`, counting execution cycles, and reports completion and the cycle count back to the host.

## Interface
Parameters:
- `AW`, 8, data-memory address width
- `CW`, 16, cycle counter width
- `MAX_CYCLES`, 16'd4000, watchdog limit in RUN cycles (used only with watchdog compiled in)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  host request to begin a load/run sequence
- `ld_valid`  in  1  host load word valid
- `ld_last`  in  1  qualifies final load word
- `ld_addr`  in  AW  load target address
- `ld_data`  in  8  load data byte
- `ld_ready`  out  1  load port accepting; reset 0
- `core_rst`  out  1  active-high reset to core; reset 1
- `core_req`  out  1  one-cycle launch pulse to core `req`; reset 0
- `core_done`  in  1  core `done`
- `dm_wr_en`  out  1  data-memory write strobe; reset 0
- `dm_addr`  out  AW  data-memory write address; reset 0
- `dm_dat`  out  8  data-memory write data; reset 0
- `busy`  out  1  high in LOAD, LAUNCH, RUN; reset 0
- `finished`  out  1  high in DONE; reset 0
- `timeout`  out  1  run ended by watchdog; reset 0
- `cycle_count`  out  CW  RUN cycles before `core_done`; reset 0

## Operation
- FSM states: IDLE, LOAD, LAUNCH, RUN, DONE. Reset enters IDLE.
- IDLE: `core_rst`=1. `start`=1 moves to LOAD and clears `timeout` and `cycle_count`.
- LOAD: `ld_ready`=1 and `core_rst`=1.
  - Each cycle with `ld_valid`=1 is an accepted word.
  - An accepted word registers `dm_wr_en`=1 with its `ld_addr`/`ld_data` on the next cycle; otherwise `dm_wr_en`=0.
  - An accepted word with `ld_last`=1 moves to LAUNCH.
  - `ld_last` without `ld_valid` is ignored.
- LAUNCH: lasts exactly one cycle. `core_rst`=0, `core_req`=1. Next state is RUN.
- RUN:
  - `core_rst`=0.
  - If `core_done`=1, move to DONE and freeze `cycle_count`.
  - Otherwise increment `cycle_count`.
  - `cycle_count` saturates at all-ones and never wraps.
- DONE: `finished`=1 and `core_rst`=0, so core state stays observable. `start`=1 restarts at LOAD with `timeout` and `cycle_count` cleared.
- `start` is ignored in LOAD, LAUNCH and RUN.
- `core_done` is ignored outside RUN.

## Timing
- Load write latency: one cycle from accepted word to `dm_wr_en`. Back-to-back words give back-to-back writes.
- The final word's write (`dm_wr_en`=1) lands in the LAUNCH cycle, before the core's first fetch.
- `core_req` is high for exactly one cycle, one cycle after the `ld_last` acceptance edge.
- `core_done` high on the first RUN cycle leaves `cycle_count`=0.
- `core_done` first high on the Nth RUN cycle leaves `cycle_count`=N-1.
- Outputs are registered from state and change only on `clk` edges. The exception is `reset` low, which forces all outputs to their reset values immediately.
- Reset low mid-LOAD or mid-RUN: return to IDLE asynchronously and drop any pending write. `core_rst` reasserts at once.

## Configuration
- `RUN_SEQ_WATCHDOG_EN` defined:
  - In RUN, when `cycle_count` reaches `MAX_CYCLES` with `core_done`=0, move to DONE with `timeout`=1.
  - `core_done`=1 in the same cycle wins: `timeout`=0.
- Undefined: no watchdog. `timeout` is tied to 0 and RUN waits indefinitely.

## Test plan
- Reset: hold `reset`=0 for 3 cycles -> IDLE, `core_rst`=1, all other outputs 0.
- Load: `start`, then 4 words addr 0..3 data A5,5A,FF,00, last on addr 3 -> four consecutive `dm_wr_en` pulses one cycle delayed with matching addr/data, then a single `core_req` pulse.
- Run count: `core_done` rises 10 cycles after `core_req` -> DONE, `finished`=1, `cycle_count`=9, `timeout`=0.
- Watchdog (macro on, `MAX_CYCLES`=20): `core_done` held 0 -> DONE after count reaches 20, `timeout`=1. Macro off, same stimulus -> still RUN after 100 cycles.
- Async reset mid-RUN at count 5 -> immediate IDLE, `core_rst`=1, `cycle_count`=0, no `core_req`.
- Restart from DONE: `start`=1, then 1 word with `ld_last` -> LOAD entered, `cycle_count` cleared, new `core_req` 2 cycles after `start`.
